// File: rtl/ild_ddnn_sequencer.sv
// LD dd,nn sequencer: fetches the low then high immediate byte and writes each to the selected register pair.
// Latency: 6 cycles from start pulse to IDLE with memory always ready, plus one per memory wait cycle.
// Backpressure: holds in RD_LO/RD_HI with Mem_Read_Req high until Mem_Ready; start pulses while busy are dropped.
module ild_ddnn_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       P2_Set_ILDddnn_BC_0,
    input  logic       P2_Set_ILDddnn_DE_0,
    input  logic       P2_Set_ILDddnn_HL_0,
    input  logic       P2_Set_ILDddnn_SP_0,
    input  logic       Mem_Ready,
    input  logic [7:0] Mem_Data,
    output logic       Mem_Read_Req,
    output logic       PC_Increment,
    output logic [1:0] PR_Pair,
    output logic       PR_Write_Low,
    output logic       PR_Write_High,
    output logic [7:0] PR_Data,
    output logic       P2_Set_CM1,
    output logic       PR_Reset_XPT,
    output logic       Busy,
    output logic [4:0] XPT
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        WR_LO = 3'd2,
        RD_HI = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t     state;
    logic       any_start;
    logic [1:0] start_pair;
    logic [4:0] xpt_inc;

    // BC wins over DE over HL over SP when pulses coincide
    always_comb begin
        any_start  = P2_Set_ILDddnn_BC_0 | P2_Set_ILDddnn_DE_0 |
                     P2_Set_ILDddnn_HL_0 | P2_Set_ILDddnn_SP_0;
        start_pair = 2'b11;
        if (P2_Set_ILDddnn_BC_0)
            start_pair = 2'b00;
        else if (P2_Set_ILDddnn_DE_0)
            start_pair = 2'b01;
        else if (P2_Set_ILDddnn_HL_0)
            start_pair = 2'b10;
        xpt_inc = (XPT == 5'd31) ? 5'd31 : XPT + 5'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            Mem_Read_Req  <= 1'b0;
            PC_Increment  <= 1'b0;
            PR_Pair       <= 2'b00;
            PR_Write_Low  <= 1'b0;
            PR_Write_High <= 1'b0;
            PR_Data       <= 8'h00;
            P2_Set_CM1    <= 1'b0;
            PR_Reset_XPT  <= 1'b0;
            Busy          <= 1'b0;
            XPT           <= 5'd0;
        end else begin
            PC_Increment  <= 1'b0;
            PR_Write_Low  <= 1'b0;
            PR_Write_High <= 1'b0;
            P2_Set_CM1    <= 1'b0;
            PR_Reset_XPT  <= 1'b0;
            case (state)
                IDLE: begin
                    XPT <= 5'd0;
                    if (any_start) begin
                        PR_Pair      <= start_pair;
                        Mem_Read_Req <= 1'b1;
                        Busy         <= 1'b1;
                        state        <= RD_LO;
                    end
                end
                RD_LO: begin
                    XPT <= xpt_inc;
                    if (Mem_Ready) begin
                        PR_Data      <= Mem_Data;
                        Mem_Read_Req <= 1'b0;
                        PR_Write_Low <= 1'b1;
                        PC_Increment <= 1'b1;
                        state        <= WR_LO;
                    end
                end
                WR_LO: begin
                    XPT          <= xpt_inc;
                    Mem_Read_Req <= 1'b1;
                    state        <= RD_HI;
                end
                RD_HI: begin
                    XPT <= xpt_inc;
                    if (Mem_Ready) begin
                        PR_Data       <= Mem_Data;
                        Mem_Read_Req  <= 1'b0;
                        PR_Write_High <= 1'b1;
                        PC_Increment  <= 1'b1;
                        state         <= WR_HI;
                    end
                end
                WR_HI: begin
                    XPT          <= 5'd0;
                    P2_Set_CM1   <= 1'b1;
                    PR_Reset_XPT <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    XPT   <= 5'd0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    XPT          <= 5'd0;
                    Busy         <= 1'b0;
                    Mem_Read_Req <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
